// File: rtl/tlb_maint_ctrl.sv
// Maintenance sequencer for the TLB write/probe port: arbitrates two requesters, issues one op
// at a time and returns a response. Define TLB_MAINT_PORT1_EN to enable requester port 1.
module tlb_maint_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        req0_valid,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_key,
  input  logic [5:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_key,
  input  logic [5:0]  req1_data,
  output logic        req1_ready,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [1:0]  resp_op,
  output logic [5:0]  resp_data,
  input  logic        resp_ready,
  output logic [31:0] tlb_read_addr,
  output logic [31:0] tlb_write_data,
  output logic        tlb_we,
  output logic        tlb_clear,
  input  logic [5:0]  tlb_read_addr_out,
  output logic        busy
);

  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpProbe = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] key_q;
  logic [5:0]  data_q;
  logic        id_q;
  logic [5:0]  resp_data_q;

  logic elig0, grant0, grant1, can_accept, accept;

  assign elig0      = req0_valid && (req0_op != 2'b00);
  assign can_accept = (state_q == StIdle) && clk_en && !rst;

`ifdef TLB_MAINT_PORT1_EN
  logic elig1;
  logic last_q, last_d;

  assign elig1  = req1_valid && (req1_op != 2'b00);
  // Round robin: on contention the port that did not win last time is granted.
  assign grant0 = elig0 && (!elig1 || last_q);
  assign grant1 = elig1 && (!elig0 || !last_q);

  always_comb begin
    last_d = last_q;
    if (accept) last_d = req1_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (clk_en) begin
      last_q <= last_d;
    end
  end
`else
  logic unused_port1;

  assign unused_port1 = ^{req1_valid, req1_op, req1_key, req1_data};
  assign grant0       = elig0;
  assign grant1       = 1'b0;
`endif

  assign req0_ready = can_accept && grant0;
  assign req1_ready = can_accept && grant1;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= 2'b00;
      key_q       <= '0;
      data_q      <= '0;
      id_q        <= 1'b0;
      resp_data_q <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= req1_ready ? req1_op   : req0_op;
        key_q  <= req1_ready ? req1_key  : req0_key;
        data_q <= req1_ready ? req1_data : req0_data;
        id_q   <= req1_ready;
      end
      // The probe result is captured on the same edge that completes a write or clear.
      if (state_q == StExec) begin
        resp_data_q <= (op_q == OpProbe) ? tlb_read_addr_out : 6'd0;
      end
    end
  end

  assign tlb_read_addr  = key_q;
  assign tlb_write_data = {26'b0, data_q};
  assign tlb_we         = (state_q == StExec) && (op_q == OpWrite);
  assign tlb_clear      = (state_q == StExec) && (op_q == OpClear);
  assign resp_valid     = (state_q == StResp);
  assign resp_id        = id_q;
  assign resp_op        = op_q;
  assign resp_data      = resp_data_q;
  assign busy           = (state_q != StIdle);

endmodule
